// File: rtl/dp_sched_pkg.sv
// Shared types and helpers for the dot-product datapath scheduler.
package dp_sched_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StLoad  = 3'd2,
        StDrain = 3'd3,
        StDone  = 3'd4
    } state_e;

    // Bits needed to index n items; n is expected to be >= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (((n - 1) >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, with wrap.
module rr_arbiter
    import dp_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    id,
    output logic               found
);

    logic [ID_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        id    = '0;
        cand  = '0;
        // Offset 1 first so the current owner is considered last.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                id    = cand;
            end
        end
    end

endmodule

// File: rtl/dot_product_scheduler.sv
// Time-shares one MAC datapath among requesters: clear, stream a vector, drain, report.
module dot_product_scheduler
    import dp_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned ADDR_WIDTH = 3,
    parameter  int unsigned VEC_LEN    = 4,
    parameter  int unsigned MAC_LAT    = 2,
    parameter  int unsigned RES_WIDTH  = 32,
    localparam int unsigned ID_W       = clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    output logic [ID_W+ADDR_WIDTH-1:0] rd_addr,
    output logic                       mac_clr,
    output logic                       mac_en,
    input  logic [RES_WIDTH-1:0]       mac_result,
    output logic [RES_WIDTH-1:0]       result,
    output logic [ID_W-1:0]            result_id,
    output logic                       result_valid
);

    localparam int unsigned DRAIN_W = clog2(MAC_LAT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ELEM  = ADDR_WIDTH'(VEC_LEN - 1);
    localparam logic [DRAIN_W-1:0]    LAST_DRAIN = DRAIN_W'(MAC_LAT);

    state_e                state_q;
    logic [ID_W-1:0]       id_q;
    logic [ID_W-1:0]       ptr_q;
    logic [ADDR_WIDTH-1:0] elem_q;
    logic [ADDR_WIDTH-1:0] elem_nxt;
    logic [DRAIN_W-1:0]    drain_q;
    logic [ID_W-1:0]       arb_id;
    logic                  arb_found;

    assign elem_nxt = elem_q + 1'b1;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .id    (arb_id),
        .found (arb_found)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            id_q         <= '0;
            ptr_q        <= ID_W'(NUM_REQ - 1);
            elem_q       <= '0;
            drain_q      <= '0;
            gnt          <= '0;
            busy         <= 1'b0;
            rd_addr      <= '0;
            mac_clr      <= 1'b0;
            mac_en       <= 1'b0;
            result       <= '0;
            result_id    <= '0;
            result_valid <= 1'b0;
        end else begin
            mac_clr      <= 1'b0;
            mac_en       <= 1'b0;
            result_valid <= 1'b0;
            unique case (state_q)
                // DONE re-arbitrates so back-to-back jobs skip the IDLE bubble.
                StIdle, StDone: begin
                    if (arb_found) begin
                        id_q    <= arb_id;
                        ptr_q   <= arb_id;
                        gnt     <= NUM_REQ'(1) << arb_id;
                        busy    <= 1'b1;
                        mac_clr <= 1'b1;
                        elem_q  <= '0;
                        state_q <= StClear;
                    end else begin
                        gnt     <= '0;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StClear: begin
                    mac_en  <= 1'b1;
                    rd_addr <= {id_q, elem_q};
                    state_q <= StLoad;
                end
                StLoad: begin
                    if (elem_q == LAST_ELEM) begin
                        rd_addr <= '0;
                        drain_q <= DRAIN_W'(1);
                        state_q <= StDrain;
                    end else begin
                        mac_en  <= 1'b1;
                        elem_q  <= elem_nxt;
                        rd_addr <= {id_q, elem_nxt};
                    end
                end
                StDrain: begin
                    if (drain_q == LAST_DRAIN) begin
                        result       <= mac_result;
                        result_id    <= id_q;
                        result_valid <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                default: begin
                    gnt     <= '0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Randomized bench: job-timeline reference model plus directed scenarios.
module tb_dot_product_scheduler;

    localparam int NR = 4;
    localparam int V  = 4;
    localparam int M  = 2;
    localparam int P  = 2 + V + M;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  req, gnt, req2, gnt2;
    logic        busy, mac_clr, mac_en, result_valid;
    logic        busy2, mac_clr2, mac_en2, result_valid2;
    logic [4:0]  rd_addr, rd_addr2;
    logic [31:0] mac_result, result, mac_result2, result2;
    logic [1:0]  result_id, result_id2;

    dot_product_scheduler u_dut (
        .clk (clk), .rst (rst), .req (req), .gnt (gnt), .busy (busy), .rd_addr (rd_addr),
        .mac_clr (mac_clr), .mac_en (mac_en), .mac_result (mac_result), .result (result),
        .result_id (result_id), .result_valid (result_valid)
    );

    dot_product_scheduler #(
        .VEC_LEN (1), .MAC_LAT (1)
    ) u_dut_short (
        .clk (clk), .rst (rst), .req (req2), .gnt (gnt2), .busy (busy2), .rd_addr (rd_addr2),
        .mac_clr (mac_clr2), .mac_en (mac_en2), .mac_result (mac_result2), .result (result2),
        .result_id (result_id2), .result_valid (result_valid2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Operand banks and MAC environment
    logic [7:0] mem_a [32];
    logic [7:0] mem_b [32];

    function automatic logic [31:0] dot(input int id, input int len);
        logic [31:0] s;
        s = 0;
        for (int e = 0; e < len; e++) s += 32'(mem_a[id * 8 + e]) * 32'(mem_b[id * 8 + e]);
        return s;
    endfunction

    logic [31:0] acc = 0, acc_d = 0, acc2 = 0;
    always @(posedge clk) begin
        if (mac_clr) acc <= 0;
        else if (mac_en) acc <= acc + 32'(mem_a[rd_addr]) * 32'(mem_b[rd_addr]);
        acc_d <= acc;
        if (mac_clr2) acc2 <= 0;
        else if (mac_en2) acc2 <= acc2 + 32'(mem_a[rd_addr2]) * 32'(mem_b[rd_addr2]);
    end
    assign mac_result  = acc_d;
    assign mac_result2 = acc2;

    // Reference model: job timeline, t=1 is the CLEAR cycle, t=P the DONE cycle
    function automatic int rr_pick(input logic [3:0] r, input int ptr);
        int j;
        for (int k = 1; k <= NR; k++) begin
            j = (ptr + k) % NR;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    int          m_t, m_id, m_ptr, m_res_id;
    bit          m_act;
    logic [31:0] m_res;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act <= 0; m_t <= 0; m_id <= 0; m_ptr <= NR - 1; m_res <= 0; m_res_id <= 0;
        end else begin
            if (m_act && m_t == P - 1) begin
                m_res    <= dot(m_id, V);
                m_res_id <= m_id;
            end
            if (!m_act || m_t == P) begin
                if (rr_pick(req, m_ptr) >= 0) begin
                    m_act <= 1;
                    m_t   <= 1;
                    m_id  <= rr_pick(req, m_ptr);
                    m_ptr <= rr_pick(req, m_ptr);
                end else begin
                    m_act <= 0;
                    m_t   <= 0;
                end
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    int cyc = 0;
    int gq[$];
    int vq[$];
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            check("gnt", 64'(gnt), m_act ? (64'(1) << m_id) : 64'(0));
            check("busy", 64'(busy), 64'(m_act));
            check("mac_clr", 64'(mac_clr), 64'(m_act && m_t == 1));
            check("mac_en", 64'(mac_en), 64'(m_act && m_t >= 2 && m_t <= 1 + V));
            if (m_act && m_t >= 2 && m_t <= 1 + V)
                check("rd_addr", 64'(rd_addr), 64'({m_id[1:0], 3'(m_t - 2)}));
            check("result_valid", 64'(result_valid), 64'(m_act && m_t == P));
            check("result", 64'(result), 64'(m_res));
            check("result_id", 64'(result_id), 64'(m_res_id));
            if (mac_clr) begin
                for (int i = 0; i < NR; i++) if (gnt[i]) gq.push_back(i);
            end
            if (result_valid) vq.push_back(cyc);
        end
    end

    task automatic wait_valid(input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (result_valid) begin
                n = i;
                break;
            end
        end
        if (n < 0) check("valid_seen", 64'(result_valid), 64'(1));
    endtask

    task automatic wait_idle(input int maxc);
        bit seen;
        seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            seen = !busy;
        end
        if (!seen) check("idle_seen", 64'(busy), 64'(0));
    endtask

    task automatic wait_en(input int maxc);
        bit seen;
        seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            seen = mac_en;
        end
        if (!seen) check("en_seen", 64'(mac_en), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, gs, vs, cnt, fv, fg;
        logic [3:0] nxt;
        req  = 0;
        req2 = 0;
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = 8'($urandom);
            mem_b[i] = 8'($urandom);
        end
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 64'(gnt), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_addr", 64'(rd_addr), 0);
        check("rst_clr_en", 64'({mac_clr, mac_en}), 0);
        check("rst_result", 64'({result, result_id, result_valid}), 0);
        check("rst_short", 64'({gnt2, busy2, mac_en2, result_valid2}), 0);
        rst = 1'b1;

        // All requesting: strict RR order, one result per job period
        @(negedge clk);
        gs = gq.size();
        vs = vq.size();
        req = 4'b1111;
        for (int i = 0; i < 60 && gq.size() < gs + 5; i++) @(negedge clk);
        req = 0;
        wait_idle(20);
        for (int k = 0; k < 5; k++) check("rr_order", 64'(gq[gs + k]), 64'(k % NR));
        for (int k = 0; k < 4; k++) check("rr_period", 64'(vq[vs + k + 1] - vq[vs + k]), 64'(P));

        // Single isolated job from requester 0
        req = 4'b0001;
        wait_valid(20, n);
        check("t1_latency", 64'(n), 64'(P));
        check("t1_id", 64'(result_id), 0);
        check("t1_result", 64'(result), 64'(dot(0, V)));
        req = 0;
        wait_idle(20);

        // Requester 2 withdraws mid-job; job still reports, no re-grant
        req = 4'b0100;
        wait_en(10);
        req = 0;
        wait_valid(20, n);
        check("drop_id", 64'(result_id), 2);
        check("drop_result", 64'(result), 64'(dot(2, V)));
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (mac_clr) cnt++;
        end
        check("drop_no_regrant", 64'(cnt), 0);

        // Job for 1 ends with 0011 pending: straight to CLEAR for 0
        req = 4'b0010;
        wait_en(10);
        req = 4'b0011;
        wait_valid(20, n);
        check("b2b_id1", 64'(result_id), 1);
        @(negedge clk);
        req = 4'b0001;
        check("b2b_gnt", 64'(gnt), 64'(4'b0001));
        check("b2b_clr", 64'(mac_clr), 1);
        check("b2b_busy", 64'(busy), 1);
        wait_valid(20, n);
        check("b2b_latency", 64'(n), 64'(P - 1));
        check("b2b_id0", 64'(result_id), 0);
        req = 0;
        wait_idle(20);

        // Asynchronous abort during LOAD element 2
        req = 4'b1000;
        for (int i = 0; i < 10 && !(mac_en && rd_addr[2:0] == 3'd2); i++) @(negedge clk);
        check("abort_at_elem2", 64'(rd_addr), 64'(5'b11010));
        #2 rst = 1'b0;
        #1;
        check("abort_gnt", 64'(gnt), 0);
        check("abort_busy", 64'(busy), 0);
        check("abort_addr", 64'(rd_addr), 0);
        check("abort_clr_en", 64'({mac_clr, mac_en}), 0);
        check("abort_result", 64'({result, result_id, result_valid}), 0);
        req = 0;
        @(posedge clk);
        #1;
        check("abort_no_valid", 64'({result_valid, busy}), 0);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0100;
        @(negedge clk);
        check("post_rst_gnt", 64'(gnt), 64'(4'b0100));
        wait_valid(20, n);
        check("post_rst_id", 64'(result_id), 2);
        req = 0;
        wait_idle(20);

        // Random requesters obeying the drop-on-own-result protocol
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            nxt = req;
            for (int i = 0; i < NR; i++) begin
                if (result_valid && result_id == 2'(i)) nxt[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 5) == 0) nxt[i] = 1'b1;
            end
            req = nxt;
        end
        req = 0;
        wait_idle(40);

        // Short configuration: VEC_LEN=1, MAC_LAT=1
        @(negedge clk);
        req2 = 4'b0010;
        cnt = 0;
        fv = -1;
        fg = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (gnt2 != 0 && fg < 0) fg = i;
            if (mac_en2) cnt++;
            if (mac_clr2 && mac_en2) check("short_clr_en", 64'(mac_clr2 & mac_en2), 0);
            if (result_valid2 && fv < 0) begin
                fv = i;
                req2 = 0;
            end
        end
        check("short_gnt_cycle", 64'(fg), 1);
        check("short_valid_cycle", 64'(fv), 4);
        check("short_en_count", 64'(cnt), 1);
        check("short_result", 64'(result2), 64'(dot(1, 1)));
        check("short_id", 64'(result_id2), 1);
        check("short_idle", 64'({gnt2, busy2}), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dot_product_scheduler.md
# dot_product_scheduler

Shares one dot-product MAC datapath among `NUM_REQ` requesters in the sorter's V2V distance/score stage. Grants the datapath round-robin and sequences each job:
- clears the accumulator,
- streams `VEC_LEN` element addresses from the granted requester's memory bank with MAC enable,
- waits out the MAC pipeline latency,
- captures the result, tagged with the requester ID.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8); `ID_W` = clog2(`NUM_REQ`), derived localparam
- `ADDR_WIDTH`, 3, element address width per bank
- `VEC_LEN`, 4, elements per job (1..2**`ADDR_WIDTH`)
- `MAC_LAT`, 2, cycles from last `mac_en` to valid `mac_result` (>=1)
- `RES_WIDTH`, 32, result width

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `req`  in  `NUM_REQ`  level request per requester
- `gnt`  out  `NUM_REQ`  one-hot grant, held for the whole job
- `busy`  out  1  high in any state other than IDLE
- `rd_addr`  out  `ID_W`+`ADDR_WIDTH`  {granted id, element index} to operand memory
- `mac_clr`  out  1  accumulator clear
- `mac_en`  out  1  accumulate enable, aligned with `rd_addr`
- `mac_result`  in  `RES_WIDTH`  accumulator output
- `result`  out  `RES_WIDTH`  captured dot product
- `result_id`  out  `ID_W`  requester owning `result`
- `result_valid`  out  1  one-cycle strobe

## Operation
- All outputs registered. Reset value of every output is 0; the state is IDLE; the RR pointer is `NUM_REQ`-1, so requester 0 wins first.
- States: IDLE, CLEAR, LOAD, DRAIN, DONE.
- IDLE: if `|req`, pick the first set bit searching from pointer+1 with wrap. Latch `id`, set the pointer to `id`, assert `gnt[id]`, go to CLEAR. Otherwise stay.
- CLEAR, 1 cycle: `mac_clr`=1, element counter = 0, then go to LOAD.
- LOAD, `VEC_LEN` cycles: `mac_en`=1, `rd_addr`={id, elem}, elem++. After elem==`VEC_LEN`-1, go to DRAIN.
- DRAIN, `MAC_LAT` cycles: `mac_en`=0. On the edge ending the last DRAIN cycle, capture `mac_result` into `result`, load `result_id`=id, set `result_valid`, go to DONE.
- DONE, 1 cycle:
  - `result_valid`=1 and `gnt[id]` still high.
  - Arbitrates like IDLE. With any request pending, go directly to CLEAR with the new grant (no IDLE bubble); otherwise go to IDLE with `gnt`=0.
- `result`/`result_id` hold their value until the next capture.
- A requester must drop `req` after seeing `result_valid` with its ID. A `req` still high in DONE is treated as a new request, subject to RR order.
- `req` deassertion mid-job is ignored; the job completes and reports.
- `req` changes of other requesters during a job have no effect until DONE/IDLE arbitration.
- Reset asserted mid-job aborts immediately. All outputs return to 0, no partial `result_valid`, the pointer is reset.

## Timing
- Edge 0 samples `req` in IDLE. Cycle 1: CLEAR, `gnt` high. Cycles 2..1+`VEC_LEN`: LOAD. Next `MAC_LAT` cycles: DRAIN. Cycle 2+`VEC_LEN`+`MAC_LAT`: DONE, `result_valid`.
- Defaults: `gnt` rises in cycle 1. `rd_addr` element 0..3 appears in cycles 2..5. `result_valid` is high in cycle 8.
- Job period: 2+`VEC_LEN`+`MAC_LAT` cycles back-to-back (8 at defaults). An isolated job occupies 1 extra IDLE cycle before it.
- `gnt` is one-hot or zero at all times. It changes only on the edge leaving IDLE or DONE.
- `mac_clr` and `mac_en` are never high in the same cycle.

## Structure
- Package `dp_sched_pkg`: state enum (IDLE=0, CLEAR=1, LOAD=2, DRAIN=3, DONE=4, 3-bit) and the clog2 helper for `ID_W`.
- Sub-module `rr_arbiter`: combinational pick of the next id from `req` and pointer, plus a `found` flag. The pointer register stays in the scheduler FSM.
- Counters in the top level:
  - element counter, `ADDR_WIDTH` bits;
  - drain counter, clog2(`MAC_LAT`+1) bits.

## Test plan
- Reset, then `req`=4'b0001 single pulse held → `gnt`=0001 in cycle 1, `mac_clr` in cycle 1, `rd_addr`=0,1,2,3 in cycles 2-5, `result_valid` in cycle 8 with `result_id`=0 and `result` = model dot product.
- `req`=4'b1111 held continuously → grants 0,1,2,3,0 in order. `result_valid` every 8 cycles. `rd_addr` upper bits equal the grant id.
- Requester 2 drops `req` during LOAD → job still completes, `result_id`=2, no extra grant to 2.
- Grant to 1 done with `req`=4'b0011 and pointer=1 → next grant 0. DONE goes straight to CLEAR, no IDLE cycle.
- `rst` low during LOAD element 2 → all outputs 0 asynchronously, no `result_valid`. After release, `req`=4'b0100 yields `gnt`=0100 (pointer reset, no stale state).
- Parameter sweep `VEC_LEN`=1, `MAC_LAT`=1 → `result_valid` at cycle 4. `mac_en` high exactly 1 cycle per job.
